// File: rtl/riscv_immencode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_immencode : 2-stage valid/ready RV32I immediate encoder with range check
// Revision 1.0
// ---------------------------------------------------------------------------
module riscv_immencode #(
   parameter int XLEN      = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [2:0]           i_imm_src,
   input  logic [XLEN-1:0]      i_imm_val,
   input  logic [XLEN-1:0]      i_base_instr,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [XLEN-1:0]      o_instr,
   output logic                 o_imm_err,
   input  logic                 i_clr_cnt,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   // Format codes shared with the core's immediate decoder
   localparam logic [2:0] c_SRC_IMM_I = 3'b000;
   localparam logic [2:0] c_SRC_IMM_S = 3'b001;
   localparam logic [2:0] c_SRC_IMM_B = 3'b010;
   localparam logic [2:0] c_SRC_IMM_U = 3'b011;
   localparam logic [2:0] c_SRC_IMM_J = 3'b100;

   logic                 r_s1_valid;
   logic [2:0]           r_s1_src;
   logic [XLEN-1:0]      r_s1_imm;
   logic [XLEN-1:0]      r_s1_base;
   logic                 r_s1_err;
   logic                 r_s2_valid;
   logic [XLEN-1:0]      r_instr;
   logic                 r_imm_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic                 w_adv1;
   logic                 w_adv2;
   logic                 w_s2_load;
   logic                 w_err;
   logic [XLEN-1:0]      w_instr;

   assign w_adv2    = !r_s2_valid || i_out_ready;
   assign w_adv1    = !r_s1_valid || w_adv2;
   assign w_s2_load = w_adv2 && r_s1_valid;

   assign o_in_ready  = w_adv1;
   assign o_out_valid = r_s2_valid;
   assign o_instr     = r_instr;
   assign o_imm_err   = r_imm_err;
   assign o_err_cnt   = r_err_cnt;

   // Sign-extension checks: the discarded upper bits must all match the kept sign bit
   always_comb begin
      w_err = 1'b0;
      case (i_imm_src)
         c_SRC_IMM_I,
         c_SRC_IMM_S: w_err = !((&i_imm_val[31:11]) || !(|i_imm_val[31:11]));
         c_SRC_IMM_B: w_err = !((&i_imm_val[31:12]) || !(|i_imm_val[31:12])) || i_imm_val[0];
         c_SRC_IMM_J: w_err = !((&i_imm_val[31:20]) || !(|i_imm_val[31:20])) || i_imm_val[0];
         c_SRC_IMM_U: w_err = |i_imm_val[11:0];
         default:     w_err = 1'b1;
      endcase
   end

   // Overwriting each immediate field both clears and fills it
   always_comb begin
      w_instr = r_s1_base;
      case (r_s1_src)
         c_SRC_IMM_I: w_instr[31:20] = r_s1_imm[11:0];
         c_SRC_IMM_S: begin
            w_instr[31:25] = r_s1_imm[11:5];
            w_instr[11:7]  = r_s1_imm[4:0];
         end
         c_SRC_IMM_B: begin
            w_instr[31]    = r_s1_imm[12];
            w_instr[30:25] = r_s1_imm[10:5];
            w_instr[11:8]  = r_s1_imm[4:1];
            w_instr[7]     = r_s1_imm[11];
         end
         c_SRC_IMM_U: w_instr[31:12] = r_s1_imm[31:12];
         c_SRC_IMM_J: begin
            w_instr[31]    = r_s1_imm[20];
            w_instr[30:21] = r_s1_imm[10:1];
            w_instr[20]    = r_s1_imm[11];
            w_instr[19:12] = r_s1_imm[19:12];
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_src   <= '0;
         r_s1_imm   <= '0;
         r_s1_base  <= '0;
         r_s1_err   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_instr    <= '0;
         r_imm_err  <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
               r_s1_src  <= i_imm_src;
               r_s1_imm  <= i_imm_val;
               r_s1_base <= i_base_instr;
               r_s1_err  <= w_err;
            end
         end
         if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_instr   <= w_instr;
               r_imm_err <= r_s1_err;
            end
         end
         // Clear wins over a same-cycle increment
         if (i_clr_cnt) begin
            r_err_cnt <= '0;
         end else if (w_s2_load && r_s1_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_immencode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_riscv_immencode : directed self-checking bench for riscv_immencode
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscv_immencode;

   localparam logic [2:0] SRC_I   = 3'b000;
   localparam logic [2:0] SRC_S   = 3'b001;
   localparam logic [2:0] SRC_B   = 3'b010;
   localparam logic [2:0] SRC_U   = 3'b011;
   localparam logic [2:0] SRC_J   = 3'b100;
   localparam logic [2:0] SRC_BAD = 3'b111;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [2:0]  i_imm_src;
   logic [31:0] i_imm_val;
   logic [31:0] i_base_instr;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_instr;
   logic        o_imm_err;
   logic        i_clr_cnt;
   logic [7:0]  o_err_cnt;

   logic        o_in_ready2;
   logic        o_out_valid2;
   logic [31:0] o_instr2;
   logic        o_imm_err2;
   logic [1:0]  o_err_cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   riscv_immencode #(.XLEN(32), .ERR_CNT_W(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_imm_src(i_imm_src), .i_imm_val(i_imm_val), .i_base_instr(i_base_instr),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_instr(o_instr),
      .o_imm_err(o_imm_err), .i_clr_cnt(i_clr_cnt), .o_err_cnt(o_err_cnt)
   );

   riscv_immencode #(.XLEN(32), .ERR_CNT_W(2)) dut2 (
      .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready2),
      .i_imm_src(i_imm_src), .i_imm_val(i_imm_val), .i_base_instr(i_base_instr),
      .o_out_valid(o_out_valid2), .i_out_ready(i_out_ready), .o_instr(o_instr2),
      .o_imm_err(o_imm_err2), .i_clr_cnt(i_clr_cnt), .o_err_cnt(o_err_cnt2)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   // One request through an empty pipeline with the sink always ready
   task automatic send(input string tag, input logic [2:0] src, input logic [31:0] imm,
                       input logic [31:0] base, input logic [31:0] exp_instr,
                       input logic exp_err);
      i_in_valid   = 1'b1;
      i_imm_src    = src;
      i_imm_val    = imm;
      i_base_instr = base;
      chk({tag, " in_ready"}, {31'd0, o_in_ready}, 32'd1);
      tick;
      i_in_valid = 1'b0;
      chk({tag, " valid@1"}, {31'd0, o_out_valid}, 32'd0);
      tick;
      chk({tag, " valid@2"}, {30'd0, o_out_valid2, o_out_valid}, 32'd3);
      chk({tag, " instr"}, o_instr, exp_instr);
      chk({tag, " instr2"}, o_instr2, exp_instr);
      chk({tag, " err"}, {30'd0, o_imm_err2, o_imm_err}, {30'd0, exp_err, exp_err});
      chk({tag, " in_ready2"}, {31'd0, o_in_ready2}, 32'd1);
      tick;
   endtask

   logic [2:0]  bp_src [6] = '{SRC_I, SRC_I, SRC_U, SRC_S, SRC_J, SRC_B};
   logic [31:0] bp_imm [6] = '{32'h00000001, 32'hFFFFF800, 32'hABCDE000,
                               32'h00000004, 32'h00000002, 32'h00000008};
   logic [31:0] bp_base[6] = '{32'h00000013, 32'h00000013, 32'h00000037,
                               32'h00002023, 32'h0000006F, 32'h00000063};
   logic [31:0] bp_exp [6] = '{32'h00100013, 32'h80000013, 32'hABCDE037,
                               32'h00002223, 32'h0020006F, 32'h00000463};

   initial begin
      logic [31:0] q[$];
      int  sent;
      int  got;
      int  cyc;
      bit  fire_in;
      bit  fire_out;

      i_rst = 1'b1; i_in_valid = 1'b0; i_imm_src = '0; i_imm_val = '0;
      i_base_instr = '0; i_out_ready = 1'b1; i_clr_cnt = 1'b0;
      tick;
      tick;
      chk("rst valid", {31'd0, o_out_valid}, 32'd0);
      chk("rst instr", o_instr, 32'd0);
      chk("rst err", {31'd0, o_imm_err}, 32'd0);
      chk("rst cnt", {24'd0, o_err_cnt}, 32'd0);
      i_rst = 1'b0;
      tick;
      chk("post-rst in_ready", {31'd0, o_in_ready}, 32'd1);

      // Each format with a legal immediate
      send("I", SRC_I, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0);
      send("S", SRC_S, 32'h000007FF, 32'h00002023, 32'h7E002FA3, 1'b0);
      send("U", SRC_U, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
      send("B", SRC_B, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
      send("J", SRC_J, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0);
      chk("cnt clean", {24'd0, o_err_cnt}, 32'd0);

      // Range / alignment / format errors still encode the truncated bits
      send("B misalign", SRC_B, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1);
      send("I range", SRC_I, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1);
      send("bad src", SRC_BAD, 32'hFFFFFFFF, 32'h00000033, 32'h00000033, 1'b1);
      chk("cnt 3", {24'd0, o_err_cnt}, 32'd3);
      chk("cnt2 3", {30'd0, o_err_cnt2}, 32'd3);
      send("J range", SRC_J, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1);
      send("U align", SRC_U, 32'h00000001, 32'h00000037, 32'h00000037, 1'b1);
      chk("cnt 5", {24'd0, o_err_cnt}, 32'd5);
      chk("cnt2 sat", {30'd0, o_err_cnt2}, 32'd3);

      // Clear coinciding with an error load
      i_in_valid = 1'b1; i_imm_src = SRC_BAD; i_imm_val = 32'h0;
      i_base_instr = 32'h12345678;
      tick;
      i_in_valid = 1'b0;
      i_clr_cnt  = 1'b1;
      tick;
      i_clr_cnt = 1'b0;
      chk("clr cnt", {24'd0, o_err_cnt}, 32'd0);
      chk("clr cnt2", {30'd0, o_err_cnt2}, 32'd0);
      chk("clr instr", o_instr, 32'h12345678);
      chk("clr err", {31'd0, o_imm_err}, 32'd1);
      tick;

      // Back-to-back stream against a randomly stalling sink
      sent = 0; got = 0; cyc = 0;
      while (got < 6 && cyc < 200) begin
         i_out_ready = (cyc > 60) ? 1'b1 : 1'($urandom_range(0, 1));
         i_in_valid  = (sent < 6);
         if (sent < 6) begin
            i_imm_src    = bp_src[sent];
            i_imm_val    = bp_imm[sent];
            i_base_instr = bp_base[sent];
         end
         @(negedge i_clk);
         chk("bp in_ready", {31'd0, o_in_ready},
             {31'd0, !(q.size() == 2 && !i_out_ready)});
         if (q.size() == 0) begin
            chk("bp idle valid", {31'd0, o_out_valid}, 32'd0);
         end else if (o_out_valid) begin
            chk("bp instr", o_instr, q[0]);
            chk("bp err", {31'd0, o_imm_err}, 32'd0);
         end
         fire_in  = i_in_valid && o_in_ready;
         fire_out = o_out_valid && i_out_ready;
         @(posedge i_clk);
         if (fire_out) begin
            void'(q.pop_front());
            got++;
         end
         if (fire_in) begin
            q.push_back(bp_exp[sent]);
            sent++;
         end
         #1;
         cyc++;
      end
      i_in_valid  = 1'b0;
      i_out_ready = 1'b1;
      chk("bp received", got, 32'd6);
      tick;
      chk("bp drained", {31'd0, o_out_valid}, 32'd0);

      // Fill both stages, then reset asynchronously mid-cycle
      i_out_ready = 1'b0;
      i_in_valid = 1'b1; i_imm_src = SRC_I; i_imm_val = 32'h00000800;
      i_base_instr = 32'h00000013;
      tick;
      tick;
      i_in_valid = 1'b0;
      chk("full in_ready", {31'd0, o_in_ready}, 32'd0);
      chk("full valid", {31'd0, o_out_valid}, 32'd1);
      chk("full instr", o_instr, 32'h80000013);
      chk("full cnt", {24'd0, o_err_cnt}, 32'd1);
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst valid", {31'd0, o_out_valid}, 32'd0);
      chk("arst cnt", {24'd0, o_err_cnt}, 32'd0);
      chk("arst instr", o_instr, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      i_out_ready = 1'b1;
      tick;
      chk("arst drop", {31'd0, o_out_valid}, 32'd0);
      send("after rst", SRC_I, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/riscv_immencode.md
Name: riscv_immencode

Overview:
- Pipelined immediate encoder, the inverse of the core's immediate decode path.
- Takes a base instruction word, a format select and a 32-bit immediate value, and returns the instruction word with the immediate scattered into the RV32I bit positions for that format.
- Flags immediates that are out of range or misaligned, and counts those errors.
- Used by the self-test instruction generator and the bench program builder: valid/ready in, valid/ready out, 2-stage pipeline.

Parameters:
- XLEN, 32, data/instruction width; only 32 is supported.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_in_valid  input  1  request valid.
- o_in_ready  output  1  request accepted when i_in_valid && o_in_ready.
- i_imm_src  input  3  format select; uses the `SRC_IMM_I/S/B/U/J codes from riscv_configs.v.
- i_imm_val  input  XLEN  immediate value (two's complement; U-format is the full shifted value).
- i_base_instr  input  XLEN  instruction word supplying opcode, rd/rs, funct fields.
- o_out_valid  output  1  result valid.
- i_out_ready  input  1  downstream accepts the result.
- o_instr  output  XLEN  encoded instruction.
- o_imm_err  output  1  range/alignment/format error for this result.
- i_clr_cnt  input  1  synchronous clear of the error counter.
- o_err_cnt  output  ERR_CNT_W  saturating count of accepted requests that had an error.

Behaviour:
- Reset (async, active-high) clears s1_valid and s2_valid, and sets o_out_valid=0, o_instr=0, o_imm_err=0, o_err_cnt=0. o_in_ready=1 once reset is released. Any request in flight at reset is dropped.
- Pipeline control:
  - adv2 = !s2_valid || i_out_ready.
  - adv1 = !s1_valid || adv2.
  - o_in_ready = adv1.
  - Stage 1 registers the request and computes err. Stage 2 registers o_instr and o_imm_err.
  - Latency: result valid 2 cycles after acceptance with no stall.
  - Throughput: 1 request per cycle.
  - o_out_valid=s2_valid. Outputs hold stable while o_out_valid && !i_out_ready.
  - No combinational path from i_in_valid to o_out_valid; o_in_ready depends combinationally on i_out_ready.
- Range/err rules, evaluated on i_imm_val:
  - I, S: bits[31:11] must all be equal.
  - B: bits[31:12] must all be equal, and bit0 must be 0.
  - J: bits[31:20] must all be equal, and bit0 must be 0.
  - U: bits[11:0] must be 0.
  - Any other i_imm_src value: err=1, and o_instr=i_base_instr unchanged.
- Encoding: immediate field positions of the base word are cleared, then filled. On error the truncated bits are still encoded.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Error counter:
  - Increments on each stage-2 load where err=1.
  - Saturates at all-ones.
  - i_clr_cnt has priority over a same-cycle increment; the result is 0.

Test Plan:
- I: base 0x00000013, imm 0xFFFFFFFF -> o_instr 0xFFF00013, err 0, valid exactly 2 cycles after accept.
- S: base 0x00002023, imm 0x000007FF -> 0x7E002FA3. U: base 0x00000037, imm 0x12345000 -> 0x12345037.
- B: base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3. J: base 0x0000006F, imm 0x00000800 -> 0x0010006F.
- Errors: B imm 0x00000003, I imm 0x00000800, invalid i_imm_src -> each has err=1, and o_err_cnt reaches 3. With ERR_CNT_W=2, 5 errors -> o_err_cnt=3. Clear asserted together with an error -> 0.
- Backpressure: stream of 6 back-to-back requests with i_out_ready toggling randomly -> all 6 results in order, none lost or duplicated, outputs stable while stalled, o_in_ready=0 only when both stages are full and i_out_ready=0.
- Reset mid-stream: assert i_rst with both stages full -> o_out_valid falls immediately (async), o_err_cnt=0. After release, the first new request returns its result correctly 2 cycles after acceptance.
